// File: rtl/i2c_simple_pkg.sv
// Shared types and constants for the i2c_simple write-only master.
package i2c_simple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_DATA,
    ST_ACK2,
    ST_STOP
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int START_QTRS    = 2;
  localparam int STOP_QTRS     = 3;
  localparam int BITS_PER_BYTE = 8;

  localparam logic [1:0] START_LAST = 2'(START_QTRS - 1);
  localparam logic [1:0] STOP_LAST  = 2'(STOP_QTRS - 1);
  localparam logic [2:0] BIT_LAST   = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: one-cycle tick every QDIV clocks.
module i2c_quarter_tick #(
  parameter int QDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_simple.sv
// Write-only I2C master: START, {ADDR,W}, ACK, DATA, ACK, STOP.
module i2c_simple
  import i2c_simple_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h50,
  parameter logic [7:0] DATA = 8'hA5,
  parameter int         QDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic scl,
  inout  wire  sda
);

  localparam logic [7:0] ADDR_BYTE = {ADDR, 1'b0};

  state_e     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       tick;
  logic       restart;

  // Counter is held in IDLE so START's first quarter is full length
  assign restart = (state_q == ST_IDLE) || (state_d != state_q);

  i2c_quarter_tick #(.QDIV(QDIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_START;
        qtr_d   = Q0;
      end
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
      unique case (state_q)
        ST_START: begin
          if (qtr_q == START_LAST) begin
            state_d = ST_ADDR;
            qtr_d   = Q0;
            bit_d   = '0;
            sh_d    = ADDR_BYTE;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (qtr_q == Q3) begin
            if (bit_q == BIT_LAST) begin
              state_d = (state_q == ST_ADDR) ? ST_ACK1 : ST_ACK2;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
        end
        ST_ACK1: begin
          if (qtr_q == Q3) begin
            state_d = ST_DATA;
            bit_d   = '0;
            sh_d    = DATA;
          end
        end
        ST_ACK2: begin
          if (qtr_q == Q3) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (qtr_q == STOP_LAST) begin
            state_d = ST_IDLE;
            qtr_d   = Q0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          qtr_d   = Q0;
        end
      endcase
    end
  end

  // Bus levels are decoded from the next state so they register with it
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    unique case (1'b1)
      (state_d == ST_START): begin
        scl_d = (qtr_d == Q0);
        sda_d = 1'b0;
      end
      (state_d == ST_ADDR),
      (state_d == ST_DATA): begin
        scl_d = qtr_d[1];
        sda_d = sh_d[7];
      end
      (state_d == ST_ACK1),
      (state_d == ST_ACK2): begin
        scl_d = qtr_d[1];
      end
      (state_d == ST_STOP): begin
        scl_d = (qtr_d != Q0);
        sda_d = (qtr_d == Q2);
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      qtr_q   <= Q0;
      bit_q   <= '0;
      sh_q    <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign scl = scl_q;
  assign sda = sda_q ? 1'bz : 1'b0;

endmodule

// File: tb/tb_i2c_simple.sv
// Bench for i2c_simple: bus decoder plus start-acceptance model.
module tb_i2c_simple;

  localparam int         Q   = 2;
  localparam logic [6:0] A   = 7'h50;
  localparam logic [7:0] D   = 8'hA5;
  localparam int         TQ  = 77 * Q;
  localparam int         WIN = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic scl;
  wire  sda;

  pullup (sda);

  i2c_simple #(.ADDR(A), .DATA(D), .QDIV(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .scl   (scl),
    .sda   (sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    int plen;
    int extra;
    int nexp;
  } vec_t;

  int total = 0;
  int bad = 0;
  bit pat [WIN];
  int starts[$], stops[$], bits[$], highs[$], lows[$], mexp[$];
  vec_t vt [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: a start is taken when requested and the bus is idle;
  // a transaction lasts 77 quarters, then one idle edge is needed.
  task automatic model();
    int nf;
    nf = 0;
    mexp.delete();
    for (int t = 0; t < WIN; t++) begin
      if (pat[t] && t >= nf) begin
        mexp.push_back(t);
        nf = t + TQ + 1;
      end
    end
  endtask

  task automatic run(input int win);
    logic ps, pd;
    int   lr, lf;
    starts.delete(); stops.delete(); bits.delete();
    highs.delete(); lows.delete();
    ps = scl; pd = sda; lr = -1; lf = -1;
    for (int t = 0; t < win; t++) begin
      start = pat[t];
      @(negedge clk);
      if (ps && scl && pd && !sda) starts.push_back(t);
      if (ps && scl && !pd && sda) stops.push_back(t);
      if (!ps && scl) begin
        bits.push_back(int'(sda));
        if (lf >= 0) lows.push_back(t - lf);
        lr = t;
      end
      if (ps && !scl) begin
        if (lr >= 0) highs.push_back(t - lr);
        lf = t;
      end
      ps = scl; pd = sda;
    end
    start = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int nexp);
    logic [17:0] ev;
    logic [17:0] gv;
    int nb, el;
    model();
    run(WIN);
    chk({tag, "_nstart"}, starts.size(), mexp.size());
    if (nexp >= 0) chk({tag, "_nexp"}, starts.size(), nexp);
    for (int i = 0; i < mexp.size() && i < starts.size(); i++)
      chk($sformatf("%s_start%0d", tag, i), starts[i], mexp[i]);
    chk({tag, "_nstop"}, stops.size(), mexp.size());
    if (starts.size() > 0 && stops.size() > 0)
      chk({tag, "_len"}, stops[0] - starts[0], 76 * Q);
    ev = {A, 1'b0, 1'b1, D, 1'b1};
    if (bits.size() >= 19) begin
      gv = '0;
      for (int i = 0; i < 18; i++) gv = {gv[16:0], bits[i][0]};
      chk({tag, "_bits"}, int'(gv), int'(ev));
    end else begin
      chk({tag, "_nrise"}, bits.size(), 19);
    end
    if (highs.size() >= 18 && lows.size() >= 19) begin
      nb = 0;
      for (int i = 0; i < 18; i++) if (highs[i] != 2 * Q) nb++;
      for (int i = 0; i < 19; i++) begin
        el = (i == 0) ? 3 * Q : (i == 18) ? Q : 2 * Q;
        if (lows[i] != el) nb++;
      end
      chk({tag, "_phases"}, nb, 0);
    end else begin
      chk({tag, "_nphase"}, highs.size() + lows.size(), 37);
    end
    chk({tag, "_idle_scl"}, int'(scl), 1);
    chk({tag, "_idle_sda"}, int'(sda), 1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_scl"}, int'(scl), 1);
    chk({tag, "_rst_sda"}, int'(sda), 1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_pat(input int plen, input int extra);
    for (int t = 0; t < WIN; t++) pat[t] = (t < plen) || (t == extra);
  endtask

  initial begin
    vt[0] = '{plen: 1,   extra: -1,  nexp: 1};
    vt[1] = '{plen: 1,   extra: 100, nexp: 1};
    vt[2] = '{plen: 6,   extra: -1,  nexp: 1};
    vt[3] = '{plen: 300, extra: -1,  nexp: 2};
    vt[4] = '{plen: 1,   extra: 154, nexp: 1};
    vt[5] = '{plen: 1,   extra: 155, nexp: 2};

    do_reset("init");
    set_pat(0, -1);
    run(50);
    chk("quiet_starts", starts.size(), 0);
    chk("quiet_rises", bits.size(), 0);
    chk("quiet_scl", int'(scl), 1);
    chk("quiet_sda", int'(sda), 1);

    for (int i = 0; i < 6; i++) begin
      set_pat(vt[i].plen, vt[i].extra);
      check_txn($sformatf("v%0d", i), vt[i].nexp);
      do_reset($sformatf("v%0d", i));
    end

    for (int k = 0; k < 8; k++) begin
      set_pat(int'($urandom_range(1, 4)), int'($urandom_range(1, 240)));
      check_txn($sformatf("r%0d", k), -1);
      do_reset($sformatf("r%0d", k));
    end

    // Reset while ADDR bit 3 is in its low phase with sda driven low
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_pre_scl", int'(scl), 0);
    chk("mid_pre_sda", int'(sda), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", int'(scl), 1);
    chk("mid_rst_sda", int'(sda), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_pat(1, -1);
    check_txn("after_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
